serial_mag_cmp_ctrl: RTL and testbench

Multi-cycle magnitude comparator controller. It compares two WIDTH-bit operands two bits per clock, most significant pair first, using a single shared 2-bit comparator slice with one-hot GT/EQ/LT outputs. A start/busy/done handshake sequences the comparison. It stops early at the first unequal bit pair. It sits above the 2-bit comparator datapath and lets wide comparisons reuse the one slice instead of replicating comparator logic.

---
 rtl/serial_mag_cmp_ctrl.sv | 126 ++++++++++++
 tb/tb_serial_mag_cmp_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/serial_mag_cmp_ctrl.sv
// Serial magnitude comparator: two bits per cycle, MS pair first, early exit on first unequal pair.
// Optional CMP_SIGNED_EN: operands treated as two's complement via MSB inversion at load.

module cmp2_slice (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       gt,
    output logic       eq,
    output logic       lt
);
    always_comb begin
        gt = (a > b);
        eq = (a == b);
        lt = (a < b);
    end
endmodule

// state  | meaning
// IDLE   | waiting for start, result regs hold last value
// RUN    | comparing one bit pair per cycle
// DONE   | one-cycle result-valid pulse, start may be accepted
module serial_mag_cmp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic             busy,
    output logic             done,
    output logic             outGT,
    output logic             outEQ,
    output logic             outLT
);
    localparam int NPAIR = WIDTH / 2;
    localparam int CW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       res_q, res_d;   // {gt, eq, lt}
    logic [WIDTH-1:0] load_a, load_b;
    logic             slice_gt, slice_eq, slice_lt;

`ifdef CMP_SIGNED_EN
    // Offset-binary mapping makes the unsigned serial compare order signed values.
    localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};
    assign load_a = inA ^ SIGN_MASK;
    assign load_b = inB ^ SIGN_MASK;
`else
    assign load_a = inA;
    assign load_b = inB;
`endif

    cmp2_slice u_slice (
        .a  (sa_q[WIDTH-1:WIDTH-2]),
        .b  (sb_q[WIDTH-1:WIDTH-2]),
        .gt (slice_gt),
        .eq (slice_eq),
        .lt (slice_lt)
    );

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    sa_d    = load_a;
                    sb_d    = load_b;
                    cnt_d   = '0;
                    res_d   = 3'b000;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (!slice_eq) begin
                    res_d   = {slice_gt, 1'b0, slice_lt};
                    state_d = S_DONE;
                end else if (cnt_q == CW'(NPAIR - 1)) begin
                    res_d   = 3'b010;
                    state_d = S_DONE;
                end else begin
                    sa_d  = sa_q << 2;
                    sb_d  = sb_q << 2;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            res_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    assign outGT = res_q[2];
    assign outEQ = res_q[1];
    assign outLT = res_q[0];

endmodule

// File: tb/tb_serial_mag_cmp_ctrl.sv
// Randomized bench for serial_mag_cmp_ctrl against an arithmetic reference model.
// Signed expectations follow CMP_SIGNED_EN when the macro is defined for the build.

module tb_serial_mag_cmp_ctrl;
    localparam int W     = 8;
    localparam int NPAIR = W / 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] inA = '0;
    logic [W-1:0] inB = '0;
    logic         busy, done, outGT, outEQ, outLT;

    int n_chk  = 0;
    int n_pass = 0;
    logic [2:0] last_res = 3'b000;

    serial_mag_cmp_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .inA   (inA),
        .inB   (inB),
        .busy  (busy),
        .done  (done),
        .outGT (outGT),
        .outEQ (outEQ),
        .outLT (outLT)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Latency is set by the highest differing bit; result by plain integer ordering.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output int k, output logic [2:0] res);
        logic [W-1:0] x;
        int p;
        x = a ^ b;
        p = -1;
        for (int i = 0; i < W; i++) if (x[i]) p = i;
        k = (p < 0) ? NPAIR : NPAIR - (p / 2);
`ifdef CMP_SIGNED_EN
        if ($signed(a) > $signed(b))      res = 3'b100;
        else if ($signed(a) < $signed(b)) res = 3'b001;
        else                              res = 3'b010;
`else
        if (a > b)      res = 3'b100;
        else if (a < b) res = 3'b001;
        else            res = 3'b010;
`endif
    endfunction

    // Entered and left just after a rising edge; leaves the DUT in DONE.
    task automatic do_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
        int k, n;
        logic [2:0] res;
        model(a, b, k, res);
        inA = a; inB = b; start = 1'b1;
        @(posedge clk); #1;
        chk("accept_busy", busy, 1);
        chk("accept_done", done, 0);
        n = 0;
        while (!done && n < NPAIR + 2) begin
            chk("run_busy", busy, 1);
            if (noise) begin
                start = 1'($urandom);
                inA = W'($urandom);
                inB = W'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk("done_seen", done, 1);
        chk("latency", n, k);
        chk("result", {outGT, outEQ, outLT}, res);
        chk("done_busy", busy, 0);
        last_res = res;
    endtask

    task automatic idle_cycle();
        start = 1'b0;
        @(posedge clk); #1;
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("hold_res", {outGT, outEQ, outLT}, last_res);
    endtask

    initial begin
        logic [W-1:0] a, b;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("reset_idle", {busy, done, outGT, outEQ, outLT}, 0);
        end

        do_cmp(8'hB4, 8'hB1, 1'b0);
        idle_cycle(); idle_cycle();
        do_cmp(8'h12, 8'h93, 1'b0);
        idle_cycle();
        do_cmp(8'h5A, 8'h5A, 1'b0);
        idle_cycle();

        // Back-to-back with start held and noise on start/operands during RUN.
        do_cmp(8'h40, 8'h3F, 1'b1);
        do_cmp(8'h3F, 8'h40, 1'b1);
        do_cmp(8'h40, 8'h3F, 1'b1);
        do_cmp(8'h3F, 8'h40, 1'b1);
        idle_cycle();

        // Reset mid-run.
        inA = 8'h55; inB = 8'h56; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("reset_run", {busy, done, outGT, outEQ, outLT}, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_reset", {busy, done, outGT, outEQ, outLT}, 0);
        last_res = 3'b000;
        do_cmp(8'h55, 8'h56, 1'b0);
        idle_cycle();

        do_cmp(8'h80, 8'h01, 1'b0);
        idle_cycle();

        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ W'(1 << $urandom_range(0, W - 1));
                default: b = W'($urandom);
            endcase
            do_cmp(a, b, 1'($urandom));
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
